cbus_arbiter: RTL and testbench
===============================

// Module: cbus_arbiter
// PURPOSE
//  N-to-1 cache bus arbiter. Merges independent cache bus masters (icache, dcache, uncached
//  path) onto the single cache bus that feeds the CBus-to-AXI bridge. Grants one master per
//  burst and holds the grant until that burst's last beat. Adds one cycle of arbitration latency.
// PARAMETERS
//  NUM_INPUTS  2  number of upstream cache bus masters (2..8); index 0 = icache by convention
// PORTS
//  clk        in   1                  clock; single clock domain
//  reset      in   1                  synchronous, active-high reset
//  ireqs      in   NUM_INPUTS x cbus_req_t   upstream requests
//  iresps     out  NUM_INPUTS x cbus_resp_t  upstream responses
//  oreq       out  cbus_req_t         merged request to the downstream bridge
//  oresp      in   cbus_resp_t        response from the downstream bridge
//  busy       out  1                  grant held (state BUSY)
//  grant_idx  out  $clog2(NUM_INPUTS) index of the current or last granted master
// BEHAVIOUR
//  - Reset (sync, high): state=IDLE, grant_idx=0, rr_ptr=0. oreq='0 and all iresps='0 in the same cycle.
//  - FSM: IDLE -> BUSY when any ireqs[i].valid is high. The winner is latched into grant_idx at that edge.
//    BUSY -> IDLE on the edge where oresp.ready && oresp.last.
//  - IDLE outputs: oreq='0 (valid=0), every iresps[i]='0. busy=0.
//  - BUSY outputs: oreq = ireqs[grant_idx], passed through combinationally, so write data and strobe
//    stream beat by beat. iresps[grant_idx] = oresp. Every other iresps[j] = '0. busy=1.
//  - Latency: request valid in cycle t -> oreq.valid in cycle t+1. Never earlier, even with a single master.
//  - Masters must keep valid and fields stable until their last beat. The grant is never revoked early.
//    A granted master dropping valid mid-burst is a protocol error and is flagged by an assertion.
//  - Burst end: on the last-beat cycle, state goes to IDLE. The next cycle is a mandatory bubble
//    (oreq.valid=0) that arbitrates. So two back-to-back bursts are separated by exactly 1 idle cycle.
//  - Non-granted masters see ready=0 and last=0 for the whole burst. Their valid is ignored, not lost.
//  - Reset asserted mid-burst: returns to IDLE next edge, outputs zeroed. The downstream bridge is
//    reset by the same signal.
//  - grant_idx arithmetic: width $clog2(NUM_INPUTS). rr_ptr wraps from NUM_INPUTS-1 to 0 (modulo N,
//    with no illegal index for non-power-of-2 N).
// CONFIGURATION
//  CBUS_ARBITER_ROUND_ROBIN_EN defined:
//   - Round-robin. Search starts at rr_ptr. On burst end, rr_ptr <= grant_idx+1 (mod N).
//   - A master that re-requests immediately gets lowest priority.
//  Undefined:
//   - Fixed priority, lowest valid index wins. rr_ptr is absent and tied to 0.
//   - Master 0 can starve others. Accepted for icache-first builds.
// STRUCTURE
//  - Shared package: cbus_req_t, cbus_resp_t, mlen_t (existing). Add arb_idx_t sized for 8 inputs
//    and localparam CBUS_ARB_MAX_INPUTS = 8.
//  - Sub-module rr_priority_picker (combinational): inputs valid vector and start pointer;
//    outputs one-hot plus index. With the macro undefined it is instantiated with the start pointer tied to 0.
//  - Top holds the FSM, grant register, rr_ptr and output muxes.
// TESTING
//  1 Single read:
//    - Stimulus: ireqs[1] read, addr=0x1000, len=3, in cycle 0; the model returns 4 beats.
//    - Response: oreq.valid first in cycle 1 with addr 0x1000. iresps[1] sees 4 ready and last on
//      beat 4. iresps[0] stays 0. busy drops the cycle after last.
//  2 Simultaneous requests, N=2, round-robin:
//    - Stimulus: both masters valid in cycle 0; each re-requests after completion, 3 times.
//    - Response: grant order 0,1,0,1,0,1, with exactly one oreq.valid=0 cycle between bursts.
//  3 Same as 2 with the macro undefined:
//    - Response: master 0 granted every time while it holds valid. Master 1 is granted only after
//      master 0 deasserts.
//  4 Write passthrough:
//    - Stimulus: ireqs[0] write, len=1, data changes per beat (0xAAAA_0001, 0xAAAA_0002),
//      strobe=4'hF; the model acks each beat.
//    - Response: oreq.data follows the live data each beat. iresps[0].last on beat 2.
//  5 Reset mid-burst:
//    - Stimulus: reset=1 on beat 2 of a len=7 read.
//    - Response: next cycle busy=0, oreq.valid=0, all iresps=0, grant_idx=0. A new request after
//      reset is served normally.
//  6 N=3 wrap:
//    - Stimulus: all three valid continuously.
//    - Response: round-robin grants 0,1,2,0 (rr_ptr wraps 2->0). No X on grant_idx at any point.

Source files
------------

// File: rtl/cbus_arbiter_pkg.sv
// Shared cache-bus types for the N-to-1 cache bus arbiter: request/response
// structs, burst length type, arbiter index type and FSM state encoding.
package cbus_arbiter_pkg;

  localparam int CBUS_ARB_MAX_INPUTS = 8;

  typedef logic [$clog2(CBUS_ARB_MAX_INPUTS)-1:0] arb_idx_t;

  // Burst length in beats minus one.
  typedef logic [7:0] mlen_t;

  typedef struct packed {
    logic        valid;
    logic        is_write;
    logic [31:0] addr;
    mlen_t       len;
    logic [3:0]  strb;
    logic [31:0] data;
  } cbus_req_t;

  typedef struct packed {
    logic        ready;
    logic        last;
    logic [31:0] data;
  } cbus_resp_t;

  typedef enum logic {
    ARB_IDLE,
    ARB_BUSY
  } arb_state_e;

  // Increment modulo num; never produces an index >= num, even for non-power-of-2 num.
  function automatic arb_idx_t arb_wrap_inc(arb_idx_t idx, int num);
    return (int'(idx) >= num - 1) ? '0 : arb_idx_t'(idx + 1'b1);
  endfunction

endpackage

// File: rtl/cbus_arbiter_if.sv
// Cache bus bundle around the arbiter: upstream master requests/responses and the
// single merged downstream port. "slave" is the arbiter's view, "master" the environment's.
interface cbus_arbiter_if #(
  parameter int NUM_INPUTS = 2
);
  import cbus_arbiter_pkg::*;

  cbus_req_t  ireqs  [NUM_INPUTS];
  cbus_resp_t iresps [NUM_INPUTS];
  cbus_req_t  oreq;
  cbus_resp_t oresp;

  modport master (output ireqs, input iresps, input oreq, output oresp);
  modport slave  (input ireqs, output iresps, output oreq, input oresp);

endinterface

// File: rtl/cbus_arbiter_rr_priority_picker.sv
// Combinational picker: first valid requester at or after start, wrapping modulo
// NUM_INPUTS. A start tied to zero turns it into a fixed lowest-index-wins picker.
module rr_priority_picker #(
  parameter  int NUM_INPUTS = 2,
  localparam int IDX_W      = $clog2(NUM_INPUTS)
) (
  input  logic [NUM_INPUTS-1:0] valid,
  input  logic [IDX_W-1:0]      start,
  output logic [NUM_INPUTS-1:0] onehot,
  output logic [IDX_W-1:0]      idx,
  output logic                  any
);

  int cand;

  // NOTE: every output gets a default before the search loop so no latch is inferred.
  always_comb begin
    onehot = '0;
    idx    = '0;
    any    = 1'b0;
    cand   = 0;
    for (int k = 0; k < NUM_INPUTS; k++) begin
      cand = int'(start) + k;
      if (cand >= NUM_INPUTS) cand = cand - NUM_INPUTS;
      for (int j = 0; j < NUM_INPUTS; j++) begin
        if (!any && valid[j] && (j == cand)) begin
          onehot[j] = 1'b1;
          idx       = IDX_W'(j);
          any       = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/cbus_arbiter.sv
// N-to-1 cache bus arbiter: one grant per burst, held until the last beat, one cycle
// of arbitration latency. Define CBUS_ARBITER_ROUND_ROBIN_EN for round-robin, else fixed priority.
module cbus_arbiter
  import cbus_arbiter_pkg::*;
#(
  parameter  int NUM_INPUTS = 2,
  localparam int IDX_W      = $clog2(NUM_INPUTS)
) (
  input  logic              clk,
  input  logic              reset,
  cbus_arbiter_if.slave     bus,
  output logic              busy,
  output logic [IDX_W-1:0]  grant_idx
);

  arb_state_e              state;
  logic [NUM_INPUTS-1:0]   grant_oh;
  logic [IDX_W-1:0]        rr_ptr;
  logic [NUM_INPUTS-1:0]   req_valid;
  logic [NUM_INPUTS-1:0]   pick_oh;
  logic [IDX_W-1:0]        pick_idx;
  logic                    pick_any;
  logic                    granted_valid;

  always_comb begin
    req_valid = '0;
    for (int i = 0; i < NUM_INPUTS; i++) req_valid[i] = bus.ireqs[i].valid;
  end

  rr_priority_picker #(.NUM_INPUTS(NUM_INPUTS)) u_picker (
    .valid  (req_valid),
    .start  (rr_ptr),
    .onehot (pick_oh),
    .idx    (pick_idx),
    .any    (pick_any)
  );

`ifndef CBUS_ARBITER_ROUND_ROBIN_EN
  assign rr_ptr = '0;
`endif

  // NOTE: sequential state uses non-blocking assignments only; reset is synchronous.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ARB_IDLE;
      grant_idx <= '0;
      grant_oh  <= NUM_INPUTS'(1);
`ifdef CBUS_ARBITER_ROUND_ROBIN_EN
      rr_ptr    <= '0;
`endif
    end else begin
      case (state)
        ARB_IDLE: begin
          if (pick_any) begin
            state     <= ARB_BUSY;
            grant_idx <= pick_idx;
            grant_oh  <= pick_oh;
          end
        end
        ARB_BUSY: begin
          if (bus.oresp.ready && bus.oresp.last) begin
            state  <= ARB_IDLE;
`ifdef CBUS_ARBITER_ROUND_ROBIN_EN
            // Just-served master drops to lowest priority for the next arbitration.
            rr_ptr <= IDX_W'(arb_wrap_inc(arb_idx_t'(grant_idx), NUM_INPUTS));
`endif
          end
        end
      endcase
    end
  end

  assign busy = (state == ARB_BUSY);

  // Granted request passes straight through so write data and strobes stream per beat.
  always_comb begin
    bus.oreq      = '0;
    granted_valid = 1'b0;
    for (int i = 0; i < NUM_INPUTS; i++) bus.iresps[i] = '0;
    for (int i = 0; i < NUM_INPUTS; i++) begin
      if (grant_oh[i]) begin
        granted_valid = bus.ireqs[i].valid;
        if (!reset && state == ARB_BUSY) begin
          bus.oreq      = bus.ireqs[i];
          bus.iresps[i] = bus.oresp;
        end
      end
    end
  end

  // A granted master must hold valid until its last beat completes.
  a_grant_held: assert property (@(posedge clk) disable iff (reset)
    (state == ARB_BUSY) |-> granted_valid);

endmodule

// File: tb/tb_cbus_arbiter.sv
// Directed scoreboard bench for cbus_arbiter: N=2 and N=3 instances, a bridge model
// that acks beats (with optional stalls), and a timing model of grant/bubble behaviour.
module tb_cbus_arbiter;
  import cbus_arbiter_pkg::*;

  typedef struct {
    int          idx;
    logic [31:0] addr;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic       sel3;
  logic       busy2, busy3;
  logic [0:0] gidx2;
  logic [1:0] gidx3;

  cbus_arbiter_if #(.NUM_INPUTS(2)) bus2 ();
  cbus_arbiter_if #(.NUM_INPUTS(3)) bus3 ();

  cbus_arbiter #(.NUM_INPUTS(2)) dut2 (
    .clk(clk), .reset(reset), .bus(bus2.slave), .busy(busy2), .grant_idx(gidx2));
  cbus_arbiter #(.NUM_INPUTS(3)) dut3 (
    .clk(clk), .reset(reset), .bus(bus3.slave), .busy(busy3), .grant_idx(gidx3));

  cbus_req_t  mreq [3];
  cbus_resp_t bresp;
  logic       bridge_stall;
  mlen_t      bbeat;

  assign bus2.ireqs[0] = sel3 ? cbus_req_t'('0) : mreq[0];
  assign bus2.ireqs[1] = sel3 ? cbus_req_t'('0) : mreq[1];
  assign bus3.ireqs[0] = sel3 ? mreq[0] : cbus_req_t'('0);
  assign bus3.ireqs[1] = sel3 ? mreq[1] : cbus_req_t'('0);
  assign bus3.ireqs[2] = sel3 ? mreq[2] : cbus_req_t'('0);
  assign bus2.oresp    = sel3 ? cbus_resp_t'('0) : bresp;
  assign bus3.oresp    = sel3 ? bresp : cbus_resp_t'('0);

  cbus_req_t  obs_oreq;
  cbus_resp_t obs_iresps [3];
  logic       obs_busy;
  logic [1:0] obs_gidx;

  assign obs_oreq      = sel3 ? bus3.oreq : bus2.oreq;
  assign obs_iresps[0] = sel3 ? bus3.iresps[0] : bus2.iresps[0];
  assign obs_iresps[1] = sel3 ? bus3.iresps[1] : bus2.iresps[1];
  assign obs_iresps[2] = sel3 ? bus3.iresps[2] : cbus_resp_t'('0);
  assign obs_busy      = sel3 ? busy3 : busy2;
  assign obs_gidx      = sel3 ? gidx3 : {1'b0, gidx2};

  // Downstream bridge model: acks unless stalled, last when beat count reaches len.
  always_comb begin
    bresp = '0;
    if (obs_oreq.valid && !bridge_stall) begin
      bresp.ready = 1'b1;
      bresp.last  = (bbeat == obs_oreq.len);
      bresp.data  = obs_oreq.addr ^ {24'h0, bbeat};
    end
  end

  always_ff @(posedge clk) begin
    if (reset)            bbeat <= '0;
    else if (bresp.ready) bbeat <= bresp.last ? '0 : bbeat + 1'b1;
  end

  // Master models
  int          left  [3];
  int          burst [3];
  int          beat  [3];
  logic [31:0] base  [3];
  logic [31:0] dbase [3];
  mlen_t       mlen  [3];
  logic        mwr   [3];

  exp_t sb [$];
  exp_t cur;
  bit   model_busy;
  int   beats;
  bit   stall_en;
  int   checks;
  int   errors;

  function automatic cbus_req_t build(int i);
    cbus_req_t r;
    r          = '0;
    r.valid    = (left[i] > 0);
    r.is_write = mwr[i];
    r.addr     = base[i] + 32'(burst[i]) * 32'h100;
    r.len      = mlen[i];
    r.strb     = mwr[i] ? 4'hF : 4'h0;
    r.data     = dbase[i] + 32'(burst[i] << 8) + 32'(beat[i] + 1);
    return r;
  endfunction

  task automatic drive();
    for (int i = 0; i < 3; i++) mreq[i] = build(i);
  endtask

  task automatic setup_master(int i, logic [31:0] a, logic [31:0] d, mlen_t l, logic w, int n);
    base[i]  = a;
    dbase[i] = d;
    mlen[i]  = l;
    mwr[i]   = w;
    left[i]  = n;
    burst[i] = 0;
    beat[i]  = 0;
  endtask

  task automatic push(int i, logic [31:0] a);
    exp_t e;
    e.idx  = i;
    e.addr = a;
    sb.push_back(e);
  endtask

  task automatic check(string tag, logic [63:0] obs, logic [63:0] expv);
    checks++;
    assert (obs === expv)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // One clock: compare at negedge, advance the model at posedge, drive at posedge+1.
  task automatic cycle();
    bit        ack, fin, any_v;
    int        np;
    cbus_req_t m;
    np  = sel3 ? 3 : 2;
    ack = 1'b0;
    fin = 1'b0;
    @(negedge clk);
    check("grant_idx_known", 64'($isunknown(obs_gidx)), 64'd0);
    check("oreq_valid", 64'(obs_oreq.valid), 64'(model_busy));
    check("busy", 64'(obs_busy), 64'(model_busy));
    if (model_busy) begin
      m   = build(cur.idx);
      ack = !bridge_stall;
      fin = ack && (beats == int'(mlen[cur.idx]));
      check("grant_idx", 64'(obs_gidx), 64'(cur.idx));
      check("oreq_addr", 64'(obs_oreq.addr), 64'(cur.addr));
      check("oreq_len", 64'(obs_oreq.len), 64'(mlen[cur.idx]));
      check("oreq_data", 64'(obs_oreq.data), 64'(m.data));
      check("oreq_wr_strb", 64'({obs_oreq.is_write, obs_oreq.strb}), 64'({m.is_write, m.strb}));
      check("resp_ready", 64'(obs_iresps[cur.idx].ready), 64'(ack));
      check("resp_last", 64'(obs_iresps[cur.idx].last), 64'(fin));
      if (ack) check("resp_data", 64'(obs_iresps[cur.idx].data), 64'(cur.addr ^ 32'(beats)));
    end
    for (int j = 0; j < np; j++)
      if (!model_busy || j != cur.idx) check("idle_resp", 64'({obs_iresps[j]}), 64'd0);
    @(posedge clk);
    if (model_busy) begin
      if (fin) begin
        model_busy = 1'b0;
        left[cur.idx]--;
        burst[cur.idx]++;
        beat[cur.idx] = 0;
      end else if (ack) begin
        beats++;
        beat[cur.idx]++;
      end
    end else begin
      any_v = 1'b0;
      for (int i = 0; i < np; i++) if (mreq[i].valid) any_v = 1'b1;
      if (any_v) begin
        check("sb_has_entry", 64'(sb.size() != 0), 64'd1);
        if (sb.size() != 0) begin
          cur        = sb.pop_front();
          model_busy = 1'b1;
          beats      = 0;
        end
      end
    end
    #1;
    bridge_stall = stall_en && ($urandom_range(0, 2) == 0);
    drive();
  endtask

  task automatic run(int max_cycles);
    int n;
    bit pending;
    n       = 0;
    pending = 1'b1;
    while (pending && n < max_cycles) begin
      cycle();
      n++;
      pending = model_busy || (sb.size() != 0) || (left[0] > 0) || (left[1] > 0) || (left[2] > 0);
    end
    check("drain_timeout", 64'(pending), 64'd0);
    cycle();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    checks       = 0;
    errors       = 0;
    sel3         = 1'b0;
    reset        = 1'b1;
    stall_en     = 1'b0;
    bridge_stall = 1'b0;
    model_busy   = 1'b0;
    beats        = 0;
    cur.idx      = 0;
    cur.addr     = '0;
    for (int i = 0; i < 3; i++) setup_master(i, '0, '0, '0, 1'b0, 0);
    drive();

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", 64'(obs_busy), 64'd0);
    check("rst_oreq_valid", 64'(obs_oreq.valid), 64'd0);
    check("rst_grant_idx", 64'(obs_gidx), 64'd0);
    check("rst_busy_n3", 64'(busy3), 64'd0);
    check("rst_grant_idx_n3", 64'(gidx3), 64'd0);
    check("rst_iresps0", 64'({obs_iresps[0]}), 64'd0);
    check("rst_iresps1", 64'({obs_iresps[1]}), 64'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Single read from master 1, four beats
    setup_master(1, 32'h1000, 32'h0, 8'd3, 1'b0, 1);
    push(1, 32'h1000);
    drive();
    run(50);
    check("grant_idx_hold", 64'(obs_gidx), 64'd1);

    // Both masters requesting three bursts each, with random bridge stalls
    setup_master(0, 32'h2000, 32'h0B00_0000, 8'd1, 1'b0, 3);
    setup_master(1, 32'h3000, 32'h0C00_0000, 8'd1, 1'b0, 3);
`ifdef CBUS_ARBITER_ROUND_ROBIN_EN
    for (int b = 0; b < 3; b++) begin
      push(0, 32'h2000 + 32'(b) * 32'h100);
      push(1, 32'h3000 + 32'(b) * 32'h100);
    end
`else
    for (int b = 0; b < 3; b++) push(0, 32'h2000 + 32'(b) * 32'h100);
    for (int b = 0; b < 3; b++) push(1, 32'h3000 + 32'(b) * 32'h100);
`endif
    stall_en = 1'b1;
    drive();
    run(200);
    stall_en     = 1'b0;
    bridge_stall = 1'b0;

    // Write with per-beat data
    setup_master(0, 32'h4000, 32'hAAAA_0000, 8'd1, 1'b1, 1);
    push(0, 32'h4000);
    drive();
    run(50);

    // Reset during beat 2 of an eight-beat read
    setup_master(1, 32'h5000, 32'h0, 8'd7, 1'b0, 1);
    push(1, 32'h5000);
    drive();
    n = 0;
    while (!(model_busy && beats == 1) && n < 20) begin
      cycle();
      n++;
    end
    check("beat2_reached", 64'(model_busy && beats == 1), 64'd1);
    reset = 1'b1;
    setup_master(1, 32'h5000, 32'h0, 8'd7, 1'b0, 0);
    drive();
    @(negedge clk);
    check("rst_cycle_oreq_valid", 64'(obs_oreq.valid), 64'd0);
    check("rst_cycle_iresps0", 64'({obs_iresps[0]}), 64'd0);
    check("rst_cycle_iresps1", 64'({obs_iresps[1]}), 64'd0);
    @(posedge clk);
    #1;
    reset      = 1'b0;
    model_busy = 1'b0;
    beats      = 0;
    @(negedge clk);
    check("post_rst_busy", 64'(obs_busy), 64'd0);
    check("post_rst_oreq_valid", 64'(obs_oreq.valid), 64'd0);
    check("post_rst_grant_idx", 64'(obs_gidx), 64'd0);
    check("post_rst_iresps0", 64'({obs_iresps[0]}), 64'd0);
    check("post_rst_iresps1", 64'({obs_iresps[1]}), 64'd0);
    setup_master(0, 32'h6000, 32'h0D00_0000, 8'd2, 1'b0, 1);
    push(0, 32'h6000);
    @(posedge clk);
    #1;
    drive();
    run(50);

    // Three masters requesting continuously on the N=3 instance
    sel3 = 1'b1;
    setup_master(0, 32'h7000, 32'h0100_0000, 8'd0, 1'b0, 2);
    setup_master(1, 32'h8000, 32'h0200_0000, 8'd0, 1'b0, 2);
    setup_master(2, 32'h9000, 32'h0300_0000, 8'd0, 1'b1, 2);
`ifdef CBUS_ARBITER_ROUND_ROBIN_EN
    for (int b = 0; b < 2; b++)
      for (int i = 0; i < 3; i++) push(i, base[i] + 32'(b) * 32'h100);
`else
    for (int i = 0; i < 3; i++)
      for (int b = 0; b < 2; b++) push(i, base[i] + 32'(b) * 32'h100);
`endif
    drive();
    run(100);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
